// File: rtl/qspi_pkg.sv
// Shared types and constants for qspi_flash_reader.
// QSPI_SEQ_READ_EN adds the HOLD_OPEN state used for sequential-read streaming.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_RESP,
    ST_CS_HIGH
`ifdef QSPI_SEQ_READ_EN
    , ST_HOLD_OPEN
`endif
  } qspi_state_e;

  localparam logic [7:0]  QSPI_CMD_READ       = 8'h03;
  localparam int unsigned QSPI_CS_HIGH_CYCLES = 2;
  localparam logic [1:0]  QSPI_RESP_OKAY      = 2'b00;
  localparam logic [1:0]  QSPI_RESP_SLVERR    = 2'b10;
  localparam logic [6:0]  QSPI_FULL_BITS      = 7'd64;
  localparam logic [6:0]  QSPI_DATA_BITS      = 7'd32;

  // Bytes arrive MSB-first in address order; the first byte lands in rdata[7:0].
  function automatic logic [31:0] qspi_le_word(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/qspi_shift_engine.sv
// SPI mode-0 bit engine: shifts out nbits_i of word_i MSB first at clk/2,
// samples so_i at each falling sclk edge and flags the final sample via done_o.
module qspi_shift_engine
  import qspi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [6:0]  nbits_i,
  input  logic [63:0] word_i,
  input  logic        so_i,
  output logic        sclk_o,
  output logic        si_o,
  output logic        done_o,
  output logic [31:0] rx_o
);

  logic        active_q;
  logic        phase_q;
  logic        sclk_q;
  logic        si_q;
  logic [6:0]  cnt_q;
  logic [63:0] tx_q;
  logic [31:0] rx_q;

  assign sclk_o = sclk_q;
  assign si_o   = si_q;
  // The last sample is folded in combinationally so the caller can latch it on the same edge.
  assign rx_o   = {rx_q[30:0], so_i};
  assign done_o = active_q && !phase_q && sclk_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      sclk_q   <= 1'b0;
      si_q     <= 1'b0;
      cnt_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      phase_q  <= 1'b0;
      sclk_q   <= 1'b0;
      si_q     <= 1'b0;
      cnt_q    <= nbits_i;
      tx_q     <= word_i;
    end else if (active_q) begin
      if (phase_q) begin
        sclk_q  <= 1'b1;
        cnt_q   <= cnt_q - 7'd1;
        phase_q <= 1'b0;
      end else begin
        if (sclk_q) begin
          rx_q <= rx_o;
        end
        sclk_q <= 1'b0;
        if (cnt_q == '0) begin
          active_q <= 1'b0;
          si_q     <= 1'b0;
        end else begin
          si_q    <= tx_q[63];
          tx_q    <= {tx_q[62:0], 1'b0};
          phase_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/qspi_flash_reader.sv
// AXI4-lite read port that turns each request into a single-bit SPI READ (0x03).
// Optional QSPI_SEQ_READ_EN keeps cs low between reads to stream consecutive words.
module qspi_flash_reader
  import qspi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned FLASH_ADDR_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  cs,
  output logic                  sclk,
  output logic                  si,
  input  logic                  so,
  output logic                  wp,
  output logic                  hold
);

  qspi_state_e state_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        cs_q;
  logic [1:0]  hold_cnt_q;
  logic [23:0] addr_q;

  logic        ar_hs;
  logic        addr_err;
  logic [23:0] req_addr;
  logic        eng_start;
  logic [6:0]  eng_nbits;
  logic [63:0] eng_word;
  logic        eng_done;
  logic [31:0] eng_rx;
  logic [31:0] rdata_d;
`ifdef QSPI_SEQ_READ_EN
  logic        pend_q;
  logic        seq_hit;
`endif

  assign ar_hs    = arvalid && arready_q;
  assign addr_err = |(araddr >> FLASH_ADDR_BITS);
  assign req_addr = 24'(araddr[FLASH_ADDR_BITS-1:0]) & 24'hFF_FFFC;
  assign rdata_d  = qspi_le_word(eng_rx);

  always_comb begin
    eng_start = (state_q == ST_SETUP);
    eng_nbits = QSPI_FULL_BITS;
    eng_word  = {QSPI_CMD_READ, addr_q, 32'h0};
`ifdef QSPI_SEQ_READ_EN
    // A wrap past the top of flash overflows into bit 24 and so never matches.
    seq_hit = (state_q == ST_HOLD_OPEN) && ar_hs && !addr_err &&
              ({1'b0, req_addr} == ({1'b0, addr_q} + 25'd4));
    if (seq_hit) begin
      eng_start = 1'b1;
      eng_nbits = QSPI_DATA_BITS;
      eng_word  = '0;
    end
`endif
  end

  qspi_shift_engine u_engine (
    .clk     (clk),
    .rst     (rst),
    .start_i (eng_start),
    .nbits_i (eng_nbits),
    .word_i  (eng_word),
    .so_i    (so),
    .sclk_o  (sclk),
    .si_o    (si),
    .done_o  (eng_done),
    .rx_o    (eng_rx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= QSPI_RESP_OKAY;
      cs_q       <= 1'b1;
      hold_cnt_q <= '0;
      addr_q     <= '0;
`ifdef QSPI_SEQ_READ_EN
      pend_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            addr_q    <= req_addr;
            if (addr_err) begin
              rresp_q <= QSPI_RESP_SLVERR;
              rdata_q <= '0;
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_SETUP;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          cs_q    <= 1'b0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (eng_done) begin
            rvalid_q <= 1'b1;
            rresp_q  <= QSPI_RESP_OKAY;
            rdata_q  <= rdata_d;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
          end else if (rready) begin
            rvalid_q   <= 1'b0;
            hold_cnt_q <= '0;
`ifdef QSPI_SEQ_READ_EN
            if (!cs_q) begin
              arready_q <= 1'b1;
              state_q   <= ST_HOLD_OPEN;
            end else begin
              state_q <= ST_CS_HIGH;
            end
`else
            cs_q    <= 1'b1;
            state_q <= ST_CS_HIGH;
`endif
          end
        end
        ST_CS_HIGH: begin
          if (hold_cnt_q == 2'(QSPI_CS_HIGH_CYCLES - 1)) begin
            hold_cnt_q <= '0;
`ifdef QSPI_SEQ_READ_EN
            if (pend_q) begin
              pend_q  <= 1'b0;
              state_q <= ST_SETUP;
            end else begin
              arready_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
`else
            arready_q <= 1'b1;
            state_q   <= ST_IDLE;
`endif
          end else begin
            hold_cnt_q <= hold_cnt_q + 2'd1;
          end
        end
`ifdef QSPI_SEQ_READ_EN
        ST_HOLD_OPEN: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            if (addr_err) begin
              rresp_q <= QSPI_RESP_SLVERR;
              rdata_q <= '0;
              state_q <= ST_RESP;
            end else if (seq_hit) begin
              addr_q  <= req_addr;
              state_q <= ST_SHIFT;
            end else begin
              addr_q     <= req_addr;
              cs_q       <= 1'b1;
              pend_q     <= 1'b1;
              hold_cnt_q <= '0;
              state_q    <= ST_CS_HIGH;
            end
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign cs      = cs_q;
  assign wp      = 1'b1;
  assign hold    = 1'b1;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Self-checking bench for qspi_flash_reader: behavioural SPI flash plus a
// request-level model of data, response code and latency (QSPI_SEQ_READ_EN aware).
`timescale 1ns/1ps
module tb_qspi_flash_reader;

  localparam int unsigned LIM = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;
  logic        so = 1'b0;
  logic [31:0] araddr = '0;
  logic        arready, rvalid, cs, sclk, si, wp, hold;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  qspi_flash_reader #(.ADDR_WIDTH(32), .FLASH_ADDR_BITS(24)) dut (
    .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .cs(cs), .sclk(sclk), .si(si), .so(so), .wp(wp), .hold(hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash image: first word b7 d0 8c c8, the rest a deterministic scramble.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'd0: return 8'hb7;
      24'd1: return 8'hd0;
      24'd2: return 8'h8c;
      24'd3: return 8'hc8;
      default: return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'h5a;
    endcase
  endfunction

  function automatic logic [31:0] fword(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
  endfunction

  // Behavioural flash: header captured on rising sclk, data driven after falling sclk.
  int          fl_n = 0, hdr_count = 0, cs_falls = 0, cs_rises = 0, sclk_rises = 0;
  int          fl_d;
  logic [7:0]  fl_b;
  logic [31:0] fl_hdr = '0;
  logic [23:0] fl_addr = '0;

  always @(negedge cs) cs_falls++;
  always @(posedge cs) begin
    cs_rises++;
    fl_n = 0;
  end
  always @(posedge sclk) begin
    sclk_rises++;
    if (!cs) begin
      if (fl_n < 32) begin
        fl_hdr = {fl_hdr[30:0], si};
        if (fl_n == 31) begin
          fl_addr = fl_hdr[23:0];
          hdr_count++;
        end
      end
      fl_n++;
    end
  end
  always @(negedge sclk) begin
    if (!cs && fl_n >= 32) begin
      fl_d = fl_n - 32;
      fl_b = fbyte(fl_addr + 24'(fl_d / 8));
      #1 so = fl_b[7 - (fl_d % 8)];
    end
  end

  // Response expectations and the per-cycle compare process.
  logic        exp_armed = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_rresp = '0;
  logic        hs_r = 1'b0, pv = 1'b0;
  logic [31:0] pd = '0;

  always @(posedge clk) hs_r = rvalid && rready;

  always @(negedge clk) begin
    if (rst) begin
      chk("wp_hold", {30'b0, wp, hold}, 32'd3);
      if (cs) chk("sclk_idle_cs_high", 32'(sclk), 32'd0);
      if (rvalid) begin
        chk("rvalid_expected", 32'(exp_armed), 32'd1);
        chk("rdata", rdata, exp_rdata);
        chk("rresp", 32'(rresp), 32'(exp_rresp));
        chk("sclk_in_resp", 32'(sclk), 32'd0);
      end
      if (pv && !hs_r) begin
        chk("rvalid_hold", 32'(rvalid), 32'd1);
        chk("rdata_hold", rdata, pd);
      end
      pv = rvalid;
      pd = rdata;
    end else begin
      pv = 1'b0;
    end
  end

  // Request-level latency model.
  logic        m_open = 1'b0;
  logic [23:0] m_prev = '0;

  function automatic int unsigned exp_latency(input logic err, input logic [23:0] wa);
    if (err) return 1;
`ifdef QSPI_SEQ_READ_EN
    if (!m_open) return 130;
    if (m_prev != 24'hFF_FFFC && wa == m_prev + 24'd4) return 65;
    return 132;
`else
    return 130;
`endif
  endfunction

  // Enter and leave at a falling clock edge.
  task automatic do_read(input logic [31:0] a, input int unsigned rdly,
                         output logic [31:0] got, output int unsigned lat);
    logic        err;
    logic [23:0] wa;
    int unsigned el, t0, n;
    int          h0, r0, f0, s0;
    err = (a[31:24] != 8'h0);
    wa  = {a[23:2], 2'b00};
    el  = exp_latency(err, wa);
    exp_rdata = err ? 32'h0 : fword(wa);
    exp_rresp = err ? 2'b10 : 2'b00;
    exp_armed = 1'b1;
    h0 = hdr_count; r0 = cs_rises; f0 = cs_falls; s0 = sclk_rises;
    got = '0; lat = 0;
    arvalid = 1'b1;
    araddr  = a;
    n = 0;
    while (!arready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      chk("arready_timeout", 32'd0, 32'd1);
      arvalid = 1'b0;
      exp_armed = 1'b0;
      return;
    end
    @(posedge clk);
    #1 arvalid = 1'b0;
    araddr = $urandom;
    @(negedge clk);
    t0 = cyc;
    n = 0;
    while (!rvalid && n < LIM) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0;
    chk("r_latency", lat, el);
    if (!rvalid) begin
      exp_armed = 1'b0;
      return;
    end
    got = rdata;
    if (err) begin
      chk("err_no_cs_fall", 32'(cs_falls - f0), 32'd0);
      chk("err_no_sclk", 32'(sclk_rises - s0), 32'd0);
    end else if (el == 65) begin
      chk("seq_no_header", 32'(hdr_count - h0), 32'd0);
      chk("seq_cs_stays_low", 32'(cs_rises - r0), 32'd0);
    end else begin
      chk("header_seen", 32'(hdr_count - h0), 32'd1);
      chk("cmd_byte", 32'(fl_hdr[31:24]), 32'h03);
      chk("addr_phase", 32'(fl_addr), 32'(wa));
    end
    for (int i = 0; i < int'(rdly); i++) begin
      @(negedge clk);
      if (!err) chk("cs_low_in_resp", 32'(cs), 32'd0);
    end
    #1 rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
    exp_armed = 1'b0;
    @(negedge clk);
`ifndef QSPI_SEQ_READ_EN
    chk("cs_high_h1", 32'(cs), 32'd1);
    chk("arready_h1", 32'(arready), 32'd0);
    @(negedge clk);
    chk("cs_high_h2", 32'(cs), 32'd1);
    chk("arready_h2", 32'(arready), 32'd0);
    @(negedge clk);
    chk("arready_h3", 32'(arready), 32'd1);
`endif
    if (!err) begin
      m_open = 1'b1;
      m_prev = wa;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, a;
    int unsigned lat, t0, r;

    #2 rst = 1'b0;
    #2;
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_si", 32'(si), 32'd0);
    chk("rst_wp_hold", {30'b0, wp, hold}, 32'd3);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("arready_at_release", 32'(arready), 32'd0);
    @(negedge clk);
    chk("arready_first_clock", 32'(arready), 32'd1);

    do_read(32'h0, 0, got, lat);
    chk("word0_literal", got, 32'hc88c_d0b7);
    chk("word0_latency_literal", lat, 32'd130);

    do_read(32'h0100_0000, 0, got, lat);
    chk("slverr_rdata_literal", got, 32'd0);
    chk("slverr_latency_literal", lat, 32'd1);

    do_read(32'h6, 0, got, lat);
    chk("misaligned_word4", got, fword(24'd4));

    do_read(32'h10, 20, got, lat);
    chk("held_word", got, fword(24'h10));

    // Reset pulse while bit 30 is on the wire.
    arvalid = 1'b1;
    araddr  = 32'h40;
    while (!arready) @(negedge clk);
    @(posedge clk);
    #1 arvalid = 1'b0;
    @(negedge clk);
    t0 = cyc;
    while (cyc < t0 + 62) @(negedge clk);
    chk("bit30_reached", 32'(fl_n), 32'd30);
    #1 rst = 1'b0;
    #1;
    chk("midrst_cs", 32'(cs), 32'd1);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_arready", 32'(arready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_open = 1'b0;
    @(negedge clk);
    chk("midrst_arready_back", 32'(arready), 32'd1);
    chk("midrst_no_rvalid", 32'(rvalid), 32'd0);

    do_read(32'h0, 0, got, lat);
    chk("after_rst_word0_literal", got, 32'hc88c_d0b7);

    do_read(32'h4, 0, got, lat);
`ifdef QSPI_SEQ_READ_EN
    chk("seq_plus4_latency_literal", lat, 32'd65);
`else
    chk("plus4_latency_literal", lat, 32'd130);
`endif
    do_read(32'hC, 0, got, lat);
`ifdef QSPI_SEQ_READ_EN
    chk("seq_plus8_latency_literal", lat, 32'd132);
`else
    chk("plus8_latency_literal", lat, 32'd130);
`endif
    do_read(32'h00FF_FFFC, 1, got, lat);
    chk("top_word", got, fword(24'hFF_FFFC));
    do_read(32'h0, 0, got, lat);
`ifdef QSPI_SEQ_READ_EN
    chk("wrap_latency_literal", lat, 32'd132);
`else
    chk("wrap_latency_literal", lat, 32'd130);
`endif

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom | 32'h0100_0000;
      else if (r < 5)  a = {8'h0, m_prev + 24'd4} | 32'($urandom_range(0, 3));
      else             a = $urandom & 32'h00FF_FFFF;
      do_read(a, $urandom_range(0, 4), got, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
